// File: rtl/ball_step_gen.sv
// Converts held direction-button levels into one-cycle step pulses with hold-to-repeat.
// One cycle from a sampled request to its pulse; no backpressure, the ball module consumes every pulse.

module ball_step_axis #(
    parameter int               TIMER_W = 26,
    parameter logic [TIMER_W-1:0] D_LOAD = '0,
    parameter logic [TIMER_W-1:0] R_LOAD = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic inc_btn,
    input  logic dec_btn,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic repeating
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               dir_q, dir_d;
    logic [TIMER_W-1:0] tmr_q, tmr_d;
    logic               inc_q, inc_d;
    logic               dec_q, dec_d;
    logic               rep_q, rep_d;

    logic req_inc, req_dec, hold;

    // Pressing both buttons at once is treated as no request.
    assign req_inc = enable & inc_btn & ~dec_btn;
    assign req_dec = enable & dec_btn & ~inc_btn;
    assign hold    = dir_q ? req_inc : req_dec;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tmr_d   = tmr_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_inc || req_dec) begin
                    inc_d   = req_inc;
                    dec_d   = req_dec;
                    dir_d   = req_inc;
                    tmr_d   = D_LOAD;
                    state_d = DELAY;
                end
            end
            DELAY, REPEAT: begin
                // Losing the latched request wins over a timer expiry on the same edge.
                if (!hold) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == '0) begin
                    inc_d   = dir_q;
                    dec_d   = ~dir_q;
                    tmr_d   = R_LOAD;
                    state_d = REPEAT;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
        rep_d = (state_d == REPEAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            tmr_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tmr_q   <= tmr_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            rep_q   <= rep_d;
        end
    end

    assign inc_pulse = inc_q;
    assign dec_pulse = dec_q;
    assign repeating = rep_q;

endmodule

module ball_step_gen #(
    parameter int SIMULATE         = 0,
    parameter int REPEAT_DELAY     = 50_000_000,
    parameter int REPEAT_RATE      = 10_000_000,
    parameter int SIM_REPEAT_DELAY = 20,
    parameter int SIM_REPEAT_RATE  = 5,
    parameter int TIMER_W          = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic x_inc_btn,
    input  logic x_dec_btn,
    input  logic y_inc_btn,
    input  logic y_dec_btn,
    output logic x_increment,
    output logic x_decrement,
    output logic y_increment,
    output logic y_decrement,
    output logic x_repeating,
    output logic y_repeating
);

    localparam int D_EFF = (SIMULATE != 0) ? SIM_REPEAT_DELAY : REPEAT_DELAY;
    localparam int R_EFF = (SIMULATE != 0) ? SIM_REPEAT_RATE  : REPEAT_RATE;
    // Loads are one less than the period because the expiry edge itself counts.
    localparam logic [TIMER_W-1:0] D_LOAD = TIMER_W'(D_EFF - 1);
    localparam logic [TIMER_W-1:0] R_LOAD = TIMER_W'(R_EFF - 1);

    ball_step_axis #(
        .TIMER_W (TIMER_W),
        .D_LOAD  (D_LOAD),
        .R_LOAD  (R_LOAD)
    ) u_x (
        .clk       (clk),
        .rst_n     (reset),
        .enable    (enable),
        .inc_btn   (x_inc_btn),
        .dec_btn   (x_dec_btn),
        .inc_pulse (x_increment),
        .dec_pulse (x_decrement),
        .repeating (x_repeating)
    );

    ball_step_axis #(
        .TIMER_W (TIMER_W),
        .D_LOAD  (D_LOAD),
        .R_LOAD  (R_LOAD)
    ) u_y (
        .clk       (clk),
        .rst_n     (reset),
        .enable    (enable),
        .inc_btn   (y_inc_btn),
        .dec_btn   (y_dec_btn),
        .inc_pulse (y_increment),
        .dec_pulse (y_decrement),
        .repeating (y_repeating)
    );

endmodule

// File: tb/tb_ball_step_gen.sv
// Directed bench for ball_step_gen with SIMULATE=1 (D=20, R=5); expected pulse edges are hand-derived.
module tb_ball_step_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    logic x_inc_btn = 1'b0, x_dec_btn = 1'b0, y_inc_btn = 1'b0, y_dec_btn = 1'b0;
    logic x_increment, x_decrement, y_increment, y_decrement, x_repeating, y_repeating;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_step_gen #(
        .SIMULATE (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .x_inc_btn   (x_inc_btn),
        .x_dec_btn   (x_dec_btn),
        .y_inc_btn   (y_inc_btn),
        .y_dec_btn   (y_dec_btn),
        .x_increment (x_increment),
        .x_decrement (x_decrement),
        .y_increment (y_increment),
        .y_decrement (y_decrement),
        .x_repeating (x_repeating),
        .y_repeating (y_repeating)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // exp = {x_inc, x_dec, y_inc, y_dec, x_rep, y_rep} after the edge.
    task automatic run_edge(input string tag, input int e,
                            input logic xi, input logic xd, input logic yi, input logic yd,
                            input logic en, input logic [5:0] exp);
        x_inc_btn = xi; x_dec_btn = xd; y_inc_btn = yi; y_dec_btn = yd; enable = en;
        @(posedge clk);
        #1;
        chk($sformatf("%s e%0d outs", tag, e),
            {26'd0, x_increment, x_decrement, y_increment, y_decrement, x_repeating, y_repeating},
            {26'd0, exp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_edge("idle", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b0);
    endtask

    initial begin
        logic p, r;
        #1;
        chk("reset outs",
            {26'd0, x_increment, x_decrement, y_increment, y_decrement, x_repeating, y_repeating}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: reset mid-REPEAT with y_dec held
        for (int e = 0; e <= 22; e++) begin
            p = (e == 0) || (e == 20);
            r = (e >= 20);
            run_edge("s1", e, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {4'b0000, 1'b0, r} | {3'b000, p, 2'b00});
        end
        #2 reset = 1'b0;
        #1;
        chk("s1 async y_rep", {31'd0, y_repeating}, 32'd0);
        chk("s1 async outs",
            {26'd0, x_increment, x_decrement, y_increment, y_decrement, x_repeating, y_repeating}, 32'd0);
        @(posedge clk); #1;
        chk("s1 held outs",
            {26'd0, x_increment, x_decrement, y_increment, y_decrement, x_repeating, y_repeating}, 32'd0);
        reset = 1'b1;
        for (int e = 0; e <= 3; e++)
            run_edge("s1post", e, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, (e == 0) ? 6'b000100 : 6'b0);
        idle(3);

        // 2: tap
        for (int e = 0; e <= 29; e++)
            run_edge("s2", e, (e <= 2), 1'b0, 1'b0, 1'b0, 1'b1, (e == 0) ? 6'b100000 : 6'b0);
        idle(2);

        // 3: hold y_dec through edge 39
        for (int e = 0; e <= 44; e++) begin
            p = (e == 0) || (e == 20) || (e == 25) || (e == 30) || (e == 35);
            r = (e >= 20) && (e <= 39);
            run_edge("s3", e, 1'b0, 1'b0, 1'b0, (e <= 39), 1'b1, {3'b000, p, 1'b0, r});
        end
        idle(2);

        // 4: conflict, then drop inc at edge 30
        for (int e = 0; e <= 35; e++)
            run_edge("s4", e, (e < 30), 1'b1, 1'b0, 1'b0, 1'b1, (e == 30) ? 6'b010000 : 6'b0);
        idle(3);

        // 5: direction swap at edge 25
        for (int e = 0; e <= 50; e++) begin
            p = (e == 0) || (e == 20);
            r = ((e >= 20) && (e <= 24)) || (e >= 46);
            run_edge("s5", e, (e <= 24), (e >= 25), 1'b0, 1'b0, 1'b1,
                     {p, ((e == 26) || (e == 46)), 2'b00, r, 1'b0});
        end
        idle(3);

        // 6: both axes together, enable low for edges 22..29
        for (int e = 0; e <= 44; e++) begin
            p = (e == 0) || (e == 20) || (e == 30);
            r = (e == 20) || (e == 21);
            run_edge("s6", e, 1'b1, 1'b0, 1'b1, 1'b0, !((e >= 22) && (e < 30)),
                     {p, 1'b0, p, 1'b0, r, r});
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
